// File: rtl/send_command_data.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | send_command_data: queues host commands as encoded bytes and paces them   |
// | out to a UART. Optional heartbeat: define SEND_HEARTBEAT_EN.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module send_command_data #(
  parameter int GAP_CYCLES       = 16,
  parameter int BUSY_TIMEOUT     = 4,
  parameter int HEARTBEAT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_arg,
  output logic       cmd_ready,
  input  logic       tx_busy,
  output logic [7:0] data_send,
  output logic       send_start,
  output logic [7:0] sent_count
);

  localparam int         c_gap_w     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int         c_busy_w    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [1:0] c_chan_host = 2'b10;
  localparam logic [7:0] c_heartbeat = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  state_t              r_state;
  logic [7:0]          r_mem [4];
  logic [1:0]          r_wr_ptr;
  logic [1:0]          r_rd_ptr;
  logic [2:0]          r_count;
  logic [c_gap_w-1:0]  r_gap_cnt;
  logic [c_busy_w-1:0] r_busy_cnt;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic [7:0]          w_byte;

  assign cmd_ready = (r_count != 3'd4);
  assign w_empty   = (r_count == 3'd0);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_byte    = {cmd_arg, cmd_op, c_chan_host};

`ifdef SEND_HEARTBEAT_EN
  localparam logic [31:0] c_hb_last = 32'(HEARTBEAT_CYCLES - 1);

  logic [31:0] r_idle_cnt;
  logic        r_hb_sel;
  logic        w_hb_fire;

  // A queued command wins over the heartbeat because IDLE checks the FIFO first.
  assign w_hb_fire = (r_state == S_IDLE) && w_empty && !tx_busy && (r_idle_cnt == c_hb_last);
  assign w_pop     = (r_state == S_LOAD) && !r_hb_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_empty && !w_hb_fire) begin
      if (r_idle_cnt != c_hb_last) begin
        r_idle_cnt <= r_idle_cnt + 32'd1;
      end
    end else begin
      r_idle_cnt <= '0;
    end
  end
`else
  assign w_pop = (r_state == S_LOAD);
`endif

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      data_send  <= 8'h00;
      send_start <= 1'b0;
      sent_count <= 8'd0;
      r_gap_cnt  <= '0;
      r_busy_cnt <= '0;
`ifdef SEND_HEARTBEAT_EN
      r_hb_sel   <= 1'b0;
`endif
    end else begin
      send_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty && !tx_busy) begin
            r_state <= S_LOAD;
`ifdef SEND_HEARTBEAT_EN
            r_hb_sel <= 1'b0;
          end else if (w_hb_fire) begin
            r_state  <= S_LOAD;
            r_hb_sel <= 1'b1;
`endif
          end
        end
        S_LOAD: begin
`ifdef SEND_HEARTBEAT_EN
          data_send <= r_hb_sel ? c_heartbeat : r_mem[r_rd_ptr];
`else
          data_send <= r_mem[r_rd_ptr];
`endif
          // Registered so the pulse lines up exactly with the START state.
          send_start <= 1'b1;
          r_state    <= S_START;
        end
        S_START: begin
          sent_count <= sent_count + 8'd1;
          r_busy_cnt <= '0;
          r_state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_busy_cnt == c_busy_w'(BUSY_TIMEOUT - 1)) begin
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == c_gap_w'(GAP_CYCLES - 1)) begin
            r_gap_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/send_command_data.md
SEND_COMMAND_DATA -- requirements
Module: send_command_data

Interface
REQ-001 Parameter GAP_CYCLES, default 16: minimum idle cycles between the end of one transmitted byte and the next send_start.
REQ-002 Parameter BUSY_TIMEOUT, default 4: maximum cycles to wait for tx_busy to rise after send_start.
REQ-003 Parameter HEARTBEAT_CYCLES, default 1000000: idle cycles before a heartbeat byte is sent (used only when SEND_HEARTBEAT_EN is defined).
REQ-004 clk  input  1  single system clock, rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  command present on cmd_op/cmd_arg.
REQ-007 cmd_op  input  3  operation code (move, get, put, interact, throw, ...).
REQ-008 cmd_arg  input  3  operation argument (e.g. target machine index).
REQ-009 cmd_ready  output  1  command queue can accept.
REQ-010 tx_busy  input  1  UART transmitter busy.
REQ-011 data_send  output  8  byte presented to the UART transmitter.
REQ-012 send_start  output  1  one-cycle pulse requesting transmission of data_send.
REQ-013 sent_count  output  8  count of bytes handed to the UART.

Function
REQ-014 Each command SHALL be encoded as data_send = {cmd_arg, cmd_op, 2'b10}.
- Channel 2'b10 is host-to-client operation.
- Channel 2'b01 is reserved for client-to-host status and SHALL never be emitted.
REQ-015 The block SHALL contain a 4-entry FIFO of encoded bytes.
- cmd_ready = (count != 4), combinational from registered count.
- Push on cmd_valid && cmd_ready.
- Push and pop in the same cycle SHALL leave count unchanged and data ordered.
REQ-016 The FSM SHALL have states IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP.
REQ-017 IDLE -> LOAD when the FIFO is not empty and tx_busy == 0.
REQ-018 LOAD SHALL pop the FIFO head into data_send and go to START.
REQ-019 START SHALL assert send_start for exactly one cycle, increment sent_count (wrapping 255 -> 0), and go to WAIT_BUSY.
REQ-020 WAIT_BUSY -> WAIT_DONE when tx_busy == 1.
- After BUSY_TIMEOUT cycles without tx_busy, go to GAP; the byte counts as sent.
REQ-021 WAIT_DONE -> GAP when tx_busy == 0.
REQ-022 GAP SHALL count GAP_CYCLES cycles, then go to IDLE.
REQ-023 Latency: a command pushed at cycle N into an empty FIFO, with the FSM in IDLE and tx_busy low, SHALL produce send_start high in cycle N+3.
- N+1: IDLE sees non-empty. N+2: LOAD. N+3: START.
REQ-024 data_send SHALL hold its value from LOAD until the next LOAD.
REQ-025 Commands offered while cmd_ready == 0 SHALL be ignored, never overwriting a queued entry.

Reset
REQ-026 On rst high, asynchronously:
- FSM to IDLE; FIFO flushed (count 0); cmd_ready = 1.
- send_start = 0, data_send = 8'h00, sent_count = 0; GAP and heartbeat counters = 0.
REQ-027 Reset mid-transmission SHALL abandon the byte in flight with no further send_start pulse.
REQ-028 Operation SHALL resume on the first clock edge after rst deasserts.

Configuration
REQ-029 Macro SEND_HEARTBEAT_EN, defined:
- An idle counter increments each cycle the FSM is in IDLE with the FIFO empty; it clears otherwise.
- On reaching HEARTBEAT_CYCLES-1, LOAD SHALL take 8'h02 (no-op heartbeat) instead of popping.
- A queued command in the same cycle SHALL take priority, and the counter clears.
REQ-030 Macro not defined: no idle counter, no heartbeat; the block sends only queued commands.

Verification
REQ-031 rst pulse mid-WAIT_DONE -> send_start 0, sent_count 0, cmd_ready 1, data_send 8'h00 immediately, no pulse afterwards.
REQ-032 Push op=3'b011, arg=3'b101 with tx_busy low, FSM in IDLE -> data_send 8'hAE, send_start high exactly cycle N+3, sent_count 1.
REQ-033 Push 5 commands back-to-back with tx_busy held high -> cmd_ready low after the 4th, 5th dropped; release tx_busy -> 4 bytes in order, each send_start separated by at least GAP_CYCLES idle cycles.
REQ-034 tx_busy never rises after send_start -> GAP entered after BUSY_TIMEOUT=4 cycles, next queued byte still sent.
REQ-035 With SEND_HEARTBEAT_EN and HEARTBEAT_CYCLES=50, no commands -> data_send 8'h02 with send_start every 50 + send + GAP cycles; without the macro -> no send_start ever.
